add_pipe_result_fifo: RTL



---
 rtl/add_pipe_pkg.sv | 18 +
 rtl/add_pipe_sync_fifo.sv | 67 ++++++
 rtl/add_pipe_result_fifo.sv | 80 ++++++++
 3 files changed

// File: rtl/add_pipe_pkg.sv
// Shared constants and types for the pipelined-adder result capture block.
package add_pipe_pkg;

  localparam int ADD_WIDTH      = 32;
  localparam int ADD_LATENCY    = 2;
  localparam int RES_FIFO_DEPTH = 4;

  localparam int PTR_W = (RES_FIFO_DEPTH > 1) ? $clog2(RES_FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(RES_FIFO_DEPTH + 1);

  typedef logic [ADD_WIDTH-1:0] add_result_t;

  // A one-entry FIFO still needs a 1-bit pointer.
  function automatic int ptr_w_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/add_pipe_sync_fifo.sv
// Result storage: circular buffer with wrap-at-DEPTH pointers and an occupancy count.
module add_pipe_sync_fifo
  import add_pipe_pkg::*;
#(
  parameter  int WIDTH = ADD_WIDTH,
  parameter  int DEPTH = RES_FIFO_DEPTH,
  localparam int PW    = ptr_w_of(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/add_pipe_result_fifo.sv
// Tracks real operand cycles through the fixed-latency adder, captures their sums
// and hands out issue credits so every issued sum is guaranteed a FIFO slot.
module add_pipe_result_fifo
  import add_pipe_pkg::*;
#(
  parameter  int WIDTH   = ADD_WIDTH,
  parameter  int LATENCY = ADD_LATENCY,
  parameter  int DEPTH   = RES_FIFO_DEPTH,
  localparam int LW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [WIDTH-1:0] pipe_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LW-1:0]    level,
  output logic             err_overrun
);

  if (LATENCY < 1 || DEPTH < LATENCY + 2) begin : g_bad_cfg
    $error("add_pipe_result_fifo: DEPTH must be >= LATENCY+2 and LATENCY >= 1");
  end

  logic [LATENCY-1:0] vsr_q, vsr_d;
  logic [LW-1:0]      inflight;
  logic [LW-1:0]      count;
  logic               full, empty;
  logic               issue_fire, push, pop;
  logic               err_q, err_d;

  assign issue_fire = issue_valid && issue_ready;
  assign push       = vsr_q[LATENCY-1];
  assign pop        = out_valid && out_ready;

  always_comb begin
    vsr_d    = vsr_q << 1;
    vsr_d[0] = issue_fire;
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + LW'(vsr_q[i]);
  end

  // Credits count both stored and in-flight results, so the bound never depends on out_ready.
  assign level       = count + inflight;
  assign issue_ready = (level < LW'(DEPTH));
  assign out_valid   = !empty;
  assign err_d       = err_q || (issue_valid && !issue_ready);
  assign err_overrun = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsr_q <= '0;
      err_q <= 1'b0;
    end else begin
      vsr_q <= vsr_d;
      err_q <= err_d;
    end
  end

  add_pipe_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push && (!full || pop)),
    .data_i  (pipe_result),
    .pop_i   (pop),
    .data_o  (out_data),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule
